// File: rtl/dda_stream_packer_pkg.sv
// Shared raycast definitions: column-word field layout and packer state encoding.
package dda_stream_packer_pkg;

   localparam int COLUMN_WORD_W = 38;
   localparam int HCOUNT_MSB    = 37;
   localparam int HCOUNT_LSB    = 29;
   localparam int HEIGHT_MSB    = 28;
   localparam int HEIGHT_LSB    = 21;
   localparam int WALLTYPE_BIT  = 20;
   localparam int MAP_MSB       = 19;
   localparam int MAP_LSB       = 16;
   localparam int WALLX_MSB     = 15;
   localparam int WALLX_LSB     = 0;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      STREAM     = 2'd1,
      DRAIN      = 2'd2
   } t_packer_state;

endpackage

// File: rtl/stream_skid_fifo2.sv
// Two-entry registered stream buffer; the head entry drives the output directly.
module stream_skid_fifo2 #(
   parameter int WIDTH = 39
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [1:0]       count_next
);

   logic [WIDTH-1:0] mem_reg [2];
   logic             rd_ptr_reg;
   logic             wr_ptr_reg;
   logic [1:0]       count_reg;

   // Callers never push when full nor pop when empty.
   always_comb begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
   end

   assign head_data  = mem_reg[rd_ptr_reg];
   assign head_valid = (count_reg != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_reg[0] <= '0;
         mem_reg[1] <= '0;
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/dda_stream_packer.sv
// DDA-out transmit packer: clamps/packs ray columns, frames them with tlast.
// Optional DDA_PACKER_STATS_EN adds stall and per-frame column counters.
module dda_stream_packer
   import dda_stream_packer_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 180
) (
   input  logic        pixel_clk_in,
   input  logic        rst_n_in,
   input  logic        frame_start_in,
   input  logic        dda_valid_in,
   input  logic [10:0] dda_hcount_in,
   input  logic [15:0] dda_line_height_in,
   input  logic        dda_wall_type_in,
   input  logic [3:0]  dda_map_data_in,
   input  logic [15:0] dda_wall_x_in,
   output logic        dda_ready_out,
   input  logic        fifo_tready_in,
   output logic        fifo_tvalid_out,
   output logic [37:0] fifo_tdata_out,
   output logic        fifo_tlast_out,
   output logic        frame_done_out,
   output logic        seq_err_out
`ifdef DDA_PACKER_STATS_EN
   ,
   output logic [15:0] stall_cycles_out,
   output logic [8:0]  frame_cols_out
`endif
);

   localparam logic [15:0] HEIGHT_CAP = 16'(SCREEN_HEIGHT);
   localparam logic [10:0] LAST_COL   = 11'(SCREEN_WIDTH - 1);
   localparam logic [10:0] COL_LIMIT  = 11'(SCREEN_WIDTH);

   t_packer_state            state_reg, state_next;
   logic                     ready_reg, ready_next;
   logic [10:0]              expected_reg;
   logic                     seq_err_reg;
   logic                     done_reg, done_next;
   logic                     start_frame;
   logic                     accept, in_range, push, pop, is_last, tlast_pop;
   logic [15:0]              height_clamped;
   logic [COLUMN_WORD_W-1:0] column_word;
   logic [COLUMN_WORD_W:0]   head;
   logic                     head_valid;
   logic [1:0]               count_next;

   assign accept   = dda_valid_in && ready_reg;
   assign in_range = (dda_hcount_in < COL_LIMIT);
   assign push     = accept && in_range;
   assign is_last  = push && (dda_hcount_in == LAST_COL);
   assign pop      = head_valid && fifo_tready_in;
   assign tlast_pop = pop && head[COLUMN_WORD_W];

   always_comb begin
      height_clamped = (dda_line_height_in > HEIGHT_CAP) ? HEIGHT_CAP : dda_line_height_in;
      column_word = '0;
      column_word[HCOUNT_MSB:HCOUNT_LSB] = dda_hcount_in[8:0];
      column_word[HEIGHT_MSB:HEIGHT_LSB] = height_clamped[7:0];
      column_word[WALLTYPE_BIT]          = dda_wall_type_in;
      column_word[MAP_MSB:MAP_LSB]       = dda_map_data_in;
      column_word[WALLX_MSB:WALLX_LSB]   = dda_wall_x_in;
   end

   stream_skid_fifo2 #(.WIDTH(COLUMN_WORD_W + 1)) u_buf (
      .clk        (pixel_clk_in),
      .rst_n      (rst_n_in),
      .push       (push),
      .push_data  ({is_last, column_word}),
      .pop        (pop),
      .head_data  (head),
      .head_valid (head_valid),
      .count_next (count_next)
   );

   always_comb begin
      state_next  = state_reg;
      start_frame = 1'b0;
      done_next   = 1'b0;
      case (state_reg)
         WAIT_FRAME: begin
            if (frame_start_in) begin
               state_next  = STREAM;
               start_frame = 1'b1;
            end
         end
         STREAM: begin
            if (is_last) state_next = DRAIN;
         end
         DRAIN: begin
            if (tlast_pop) begin
               state_next = WAIT_FRAME;
               done_next  = 1'b1;
            end
         end
         default: state_next = WAIT_FRAME;
      endcase
      // Registered ready looks at post-update occupancy, so a full buffer never sees a push.
      ready_next = (state_next == STREAM) && (count_next != 2'd2);
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg    <= WAIT_FRAME;
         ready_reg    <= 1'b0;
         expected_reg <= '0;
         seq_err_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= ready_next;
         done_reg  <= done_next;
         if (start_frame) begin
            expected_reg <= '0;
            seq_err_reg  <= 1'b0;
         end else if (accept) begin
            expected_reg <= expected_reg + 11'd1;
            if (!in_range || (dda_hcount_in != expected_reg)) seq_err_reg <= 1'b1;
         end
      end
   end

   assign dda_ready_out   = ready_reg;
   assign fifo_tvalid_out = head_valid;
   assign fifo_tdata_out  = head[COLUMN_WORD_W-1:0];
   assign fifo_tlast_out  = head_valid && head[COLUMN_WORD_W];
   assign frame_done_out  = done_reg;
   assign seq_err_out     = seq_err_reg;

`ifdef DDA_PACKER_STATS_EN
   logic [15:0] stall_reg;
   logic [8:0]  col_count_reg;
   logic [8:0]  frame_cols_reg;

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stall_reg      <= '0;
         col_count_reg  <= '0;
         frame_cols_reg <= '0;
      end else if (start_frame) begin
         stall_reg      <= '0;
         col_count_reg  <= '0;
         frame_cols_reg <= '0;
      end else begin
         if (head_valid && !fifo_tready_in && (stall_reg != 16'hFFFF))
            stall_reg <= stall_reg + 16'd1;
         if (accept && (col_count_reg != 9'h1FF))
            col_count_reg <= col_count_reg + 9'd1;
         if (tlast_pop)
            frame_cols_reg <= col_count_reg;
      end
   end

   assign stall_cycles_out = stall_reg;
   assign frame_cols_out   = frame_cols_reg;
`endif

endmodule

// File: tb/tb_dda_stream_packer.sv
// Directed-vector bench for dda_stream_packer: full frames, clamp, stall, sequence errors, mid-frame reset.
module tb_dda_stream_packer;

   typedef struct {
      logic [10:0] hc;
      logic [15:0] lh;
      logic        wt;
      logic [3:0]  md;
      logic [15:0] wx;
      logic [37:0] word;
      logic        last;
   } vec_t;

   logic        pixel_clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        frame_start_in = 1'b0;
   logic        dda_valid_in = 1'b0;
   logic [10:0] dda_hcount_in = '0;
   logic [15:0] dda_line_height_in = '0;
   logic        dda_wall_type_in = 1'b0;
   logic [3:0]  dda_map_data_in = '0;
   logic [15:0] dda_wall_x_in = '0;
   logic        dda_ready_out;
   logic        fifo_tready_in = 1'b1;
   logic        fifo_tvalid_out;
   logic [37:0] fifo_tdata_out;
   logic        fifo_tlast_out;
   logic        frame_done_out;
   logic        seq_err_out;
`ifdef DDA_PACKER_STATS_EN
   logic [15:0] stall_cycles_out;
   logic [8:0]  frame_cols_out;
`endif

   dda_stream_packer dut (
      .pixel_clk_in       (pixel_clk_in),
      .rst_n_in           (rst_n_in),
      .frame_start_in     (frame_start_in),
      .dda_valid_in       (dda_valid_in),
      .dda_hcount_in      (dda_hcount_in),
      .dda_line_height_in (dda_line_height_in),
      .dda_wall_type_in   (dda_wall_type_in),
      .dda_map_data_in    (dda_map_data_in),
      .dda_wall_x_in      (dda_wall_x_in),
      .dda_ready_out      (dda_ready_out),
      .fifo_tready_in     (fifo_tready_in),
      .fifo_tvalid_out    (fifo_tvalid_out),
      .fifo_tdata_out     (fifo_tdata_out),
      .fifo_tlast_out     (fifo_tlast_out),
      .frame_done_out     (frame_done_out),
      .seq_err_out        (seq_err_out)
`ifdef DDA_PACKER_STATS_EN
      ,
      .stall_cycles_out   (stall_cycles_out),
      .frame_cols_out     (frame_cols_out)
`endif
   );

   always #5 pixel_clk_in = ~pixel_clk_in;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int beats = 0;
   int last_cyc = -10;
   int done_cnt = 0;
   int done_cyc = -20;
   logic [38:0] exp_q[$];
   vec_t vecs [320];

   always @(posedge pixel_clk_in) cyc <= cyc + 1;

   // Beat monitor: every accepted beat must match the next expected {tlast, word}.
   always @(negedge pixel_clk_in) begin
      if (rst_n_in && fifo_tvalid_out && fifo_tready_in) begin
         logic [38:0] e;
         beats++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got %h tlast=%0b, required no beat", fifo_tdata_out, fifo_tlast_out);
         end else begin
            e = exp_q.pop_front();
            if ({fifo_tlast_out, fifo_tdata_out} !== e) begin
               errors++;
               $display("FAIL beat_word: got tlast=%0b %h, required tlast=%0b %h",
                        fifo_tlast_out, fifo_tdata_out, e[38], e[37:0]);
            end else begin
               $display("beat col=%0d tlast=%0b ok", fifo_tdata_out[37:29], fifo_tlast_out);
            end
         end
         if (fifo_tlast_out) last_cyc = cyc;
      end
      if (frame_done_out) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic tick();
      @(posedge pixel_clk_in);
      #1;
   endtask

   task automatic pulse_start();
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
   endtask

   task automatic send(input vec_t v, input bit expect_beat);
      bit ok;
      ok = 1'b0;
      dda_hcount_in      = v.hc;
      dda_line_height_in = v.lh;
      dda_wall_type_in   = v.wt;
      dda_map_data_in    = v.md;
      dda_wall_x_in      = v.wx;
      dda_valid_in       = 1'b1;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge pixel_clk_in);
         if (dda_ready_out) begin
            tick();
            ok = 1'b1;
         end
      end
      dda_valid_in = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: col %0d never accepted, required accept", v.hc);
      end else if (expect_beat) begin
         exp_q.push_back({v.last, v.word});
      end
   endtask

   task automatic send_range(input int first, input int last_i);
      for (int i = first; i <= last_i; i++) send(vecs[i], 1'b1);
   endtask

   task automatic finish_frame(input string name, input int prev_done, input logic seq_req);
      for (int n = 0; n < 2000 && done_cnt == prev_done; n++) @(negedge pixel_clk_in);
      repeat (3) tick();
      chk({name, "_done_count"}, 64'(done_cnt - prev_done), 64'd1);
      chk({name, "_done_timing"}, 64'(done_cyc - last_cyc), 64'd1);
      chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_seq_err"}, 64'(seq_err_out), 64'(seq_req));
   endtask

   initial begin
      vec_t v;
      logic [37:0] held;
      int b;
      for (int i = 0; i < 320; i++) begin
         logic [10:0] c;
         c = 11'(i);
         v.hc = c;
         v.lh = 16'(i % 150);
         v.wt = c[0];
         v.md = c[3:0];
         v.wx = 16'(i * 7);
         v.word = {c[8:0], v.lh[7:0], v.wt, v.md, v.wx};
         v.last = (i == 319);
         vecs[i] = v;
      end
      // Hand-computed clamp boundaries.
      vecs[5]  = '{11'd5,  16'd400,   1'b0, 4'd1, 16'hBEEF, {9'd5,  8'd180, 1'b0, 4'd1, 16'hBEEF}, 1'b0};
      vecs[6]  = '{11'd6,  16'd180,   1'b1, 4'd6, 16'h0001, {9'd6,  8'd180, 1'b1, 4'd6, 16'h0001}, 1'b0};
      vecs[7]  = '{11'd7,  16'd181,   1'b0, 4'd7, 16'h1234, {9'd7,  8'd180, 1'b0, 4'd7, 16'h1234}, 1'b0};
      vecs[8]  = '{11'd8,  16'd256,   1'b1, 4'd8, 16'hFFFF, {9'd8,  8'd180, 1'b1, 4'd8, 16'hFFFF}, 1'b0};
      vecs[9]  = '{11'd9,  16'd179,   1'b0, 4'd9, 16'h0000, {9'd9,  8'd179, 1'b0, 4'd9, 16'h0000}, 1'b0};
      vecs[10] = '{11'd10, 16'hFFFF,  1'b1, 4'hF, 16'hA5A5, {9'd10, 8'd180, 1'b1, 4'hF, 16'hA5A5}, 1'b0};

      // Reset state
      repeat (3) tick();
      chk("rst_ready", 64'(dda_ready_out), 64'd0);
      chk("rst_tvalid", 64'(fifo_tvalid_out), 64'd0);
      chk("rst_tdata", 64'(fifo_tdata_out), 64'd0);
      chk("rst_tlast", 64'(fifo_tlast_out), 64'd0);
      chk("rst_done", 64'(frame_done_out), 64'd0);
      chk("rst_seq_err", 64'(seq_err_out), 64'd0);
      rst_n_in = 1'b1;
      repeat (2) tick();
      chk("idle_ready", 64'(dda_ready_out), 64'd0);

      // Frame 1: full frame, tready always high
      pulse_start();
      chk("f1_ready_after_start", 64'(dda_ready_out), 64'd1);
      send_range(0, 319);
      finish_frame("f1", 0, 1'b0);
      chk("f1_beats", 64'(beats), 64'd320);
      chk("f1_ready_idle", 64'(dda_ready_out), 64'd0);
`ifdef DDA_PACKER_STATS_EN
      chk("f1_stall", 64'(stall_cycles_out), 64'd0);
      chk("f1_cols", 64'(frame_cols_out), 64'd320);
`endif

      // Frame 2: 10-cycle back-pressure mid-frame
      pulse_start();
      b = beats;
      fork
         send_range(0, 319);
         begin
            for (int n = 0; n < 1000 && beats < b + 100; n++) @(negedge pixel_clk_in);
            tick();
            fifo_tready_in = 1'b0;
            for (int k = 0; k < 10; k++) begin
               @(negedge pixel_clk_in);
               if (k == 0) held = fifo_tdata_out;
               else chk("stall_tdata_stable", 64'(fifo_tdata_out), 64'(held));
               if (k == 9) begin
                  chk("stall_tvalid", 64'(fifo_tvalid_out), 64'd1);
                  chk("stall_ready_low", 64'(dda_ready_out), 64'd0);
               end
               tick();
            end
            fifo_tready_in = 1'b1;
         end
      join
      finish_frame("f2", 1, 1'b0);
      chk("f2_beats", 64'(beats - b), 64'd320);
`ifdef DDA_PACKER_STATS_EN
      chk("f2_stall", 64'(stall_cycles_out), 64'd10);
      chk("f2_cols", 64'(frame_cols_out), 64'd320);
`endif

      // Frame 3: skipped column 2 sets the sticky error; frame_start mid-frame ignored
      pulse_start();
      send(vecs[0], 1'b1);
      send(vecs[1], 1'b1);
      chk("seq_ok_after_col1", 64'(seq_err_out), 64'd0);
      send(vecs[3], 1'b1);
      chk("seq_err_after_col3", 64'(seq_err_out), 64'd1);
      pulse_start();
      chk("seq_err_survives_start", 64'(seq_err_out), 64'd1);
      send_range(4, 319);
      finish_frame("f3", 2, 1'b1);

      // Frame 4: out-of-range column dropped, then reset with two columns buffered
      pulse_start();
      chk("f4_seq_err_cleared", 64'(seq_err_out), 64'd0);
      send(vecs[0], 1'b1);
      repeat (3) tick();
      b = beats;
      v = vecs[0];
      v.hc = 11'd400;
      send(v, 1'b0);
      repeat (3) tick();
      chk("oob_no_beat", 64'(beats - b), 64'd0);
      chk("oob_seq_err", 64'(seq_err_out), 64'd1);
      fifo_tready_in = 1'b0;
      send(vecs[1], 1'b0);
      send(vecs[2], 1'b0);
      tick();
      chk("prerst_tvalid", 64'(fifo_tvalid_out), 64'd1);
      chk("prerst_ready", 64'(dda_ready_out), 64'd0);
      @(negedge pixel_clk_in);
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("midrst_tvalid", 64'(fifo_tvalid_out), 64'd0);
      chk("midrst_tlast", 64'(fifo_tlast_out), 64'd0);
      chk("midrst_ready", 64'(dda_ready_out), 64'd0);
      chk("midrst_seq_err", 64'(seq_err_out), 64'd0);
      @(negedge pixel_clk_in);
      rst_n_in = 1'b1;
      fifo_tready_in = 1'b1;
      repeat (3) tick();
      chk("postrst_ready", 64'(dda_ready_out), 64'd0);
      chk("postrst_tvalid", 64'(fifo_tvalid_out), 64'd0);

      // Frame 5: clean restart from column 0
      b = beats;
      pulse_start();
      send_range(0, 319);
      finish_frame("f5", 3, 1'b0);
      chk("f5_beats", 64'(beats - b), 64'd320);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "timeout");
   end

endmodule
